uart_wrapper: RTL and testbench
===============================

# uart_wrapper

Front end of the remote-command path. Receives 3-byte command frames (opcode, data high byte, data low byte) over a UART serial line, presents them to `cmd_cfg` as `cmd`/`data` with a `cmd_rdy` flag, and serialises single-byte responses (`resp`, typically 0xA5) back to the remote when `cmd_cfg` pulses `send_resp`. It sits directly upstream of `cmd_cfg` and is the only block touching the RX/TX pins.

## Interface
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud); sim benches override it with 16.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- RX  in  1  serial input, idle high, 8N1 LSB-first; asynchronous to clk
- TX  out  1  serial output, idle high, 8N1 LSB-first
- clr_cmd_rdy  in  1  from cmd_cfg; knocks down cmd_rdy
- send_resp  in  1  single-cycle pulse; transmit resp
- resp  in  8  response byte; sampled on the send_resp cycle
- cmd_rdy  out  1  complete frame valid on cmd/data
- cmd  out  8  frame byte 0 (opcode)
- data  out  16  {frame byte 1, frame byte 2}
- resp_sent  out  1  one-cycle pulse when TX stop bit completes

## Operation
- Reset values: cmd 0x00, data 0x0000, cmd_rdy 0, TX 1, resp_sent 0; frame FSM in CMD.
- RX is double-flopped before use (metastability).
- Receiver: detects falling edge of the synchronised RX, waits 1.5·BAUD_DIV to sample bit 0 mid-bit, then samples every BAUD_DIV; after 8 data bits and the stop-bit sample it pulses internal rx_rdy with rx_data. Stop bit is not checked (no framing-error output).
- Frame FSM (states CMD, DHI, DLO), advances only on rx_rdy:
  - CMD: cmd ← rx_data; cmd_rdy ← 0; go DHI.
  - DHI: data[15:8] ← rx_data; go DLO.
  - DLO: data[7:0] ← rx_data; cmd_rdy ← 1; go CMD.
- cmd_rdy: set by DLO capture, cleared by clr_cmd_rdy or by a new opcode byte arriving. If set and clear happen in the same cycle, set wins.
- cmd/data hold their values until overwritten by the next frame. Bytes are not held back while cmd_rdy is high.
- Transmitter: idle TX=1. send_resp loads {1, resp, 0} into a 10-bit shift register and starts shifting at BAUD_DIV per bit. After the stop bit it pulses resp_sent and returns to idle.
- send_resp while the transmitter is busy is ignored. The current byte is not corrupted.
- No inter-byte timeout: a partial frame waits indefinitely. Only reset resynchronises the FSM.

## Timing
- Frame → cmd_rdy: cmd_rdy goes high on the clock after the internal rx_rdy for byte 2. That is about 2 sync cycles + 9.5·BAUD_DIV after the byte-2 start edge.
- clr_cmd_rdy → cmd_rdy low on the next clock edge.
- send_resp at cycle t → TX falls (start bit) at t+1. Each bit lasts exactly BAUD_DIV cycles. resp_sent pulses at t+1+10·BAUD_DIV, and TX is already back to 1 by then.
- rst_n assertion mid-frame or mid-transmit: all of the following reset immediately and asynchronously: TX 1, FSM CMD, baud and bit counters 0, cmd_rdy 0.
- Receive and transmit are fully independent and may run simultaneously.

## Structure
- Shared package `quad_pkg`: frame state enum (CMD, DHI, DLO), POS_ACK constant 8'hA5, default BAUD_DIV.
- Sub-module `UART`: RX and TX halves with BAUD_DIV parameter. Ports: rx_rdy, clr_rx_rdy, rx_data, trmt, tx_data, tx_done.
- `uart_wrapper` contains the frame FSM, the cmd/data/cmd_rdy registers, and the send_resp → trmt glue.

## Test plan
- Frame 0x02, 0x12, 0x34 on RX (BAUD_DIV=16) → cmd=0x02, data=0x1234, cmd_rdy=1 one clock after byte-3 capture.
- clr_cmd_rdy pulse → cmd_rdy=0 next clock. Then send frame 0x05, 0xFF, 0x80 → cmd=0x05, data=0xFF80, and cmd_rdy drops on the 0x05 capture if not already cleared.
- send_resp with resp=0xA5 → TX shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each 16 cycles. resp_sent pulses once.
- Second send_resp mid-transmission of 0xA5 → ignored; the waveform is identical to the single-send case.
- Reset asserted after byte 2 of a frame → cmd_rdy=0, TX=1. Then the full frame 0x03, 0x00, 0x64 → cmd=0x03, data=0x0064 (no stale DHI byte).
- clr_cmd_rdy coincident with the byte-3 capture → cmd_rdy=1 (set wins).

Source files
------------

// File: rtl/quad_pkg.sv
// Definitions shared by the remote-command path: frame states, the
// positive-acknowledge byte and the default bit period.
package quad_pkg;

  typedef enum logic [1:0] {
    CMD,
    DHI,
    DLO
  } frame_state_t;

  localparam logic [7:0]  POS_ACK          = 8'hA5;
  localparam int unsigned DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/UART.sv
// 8N1 UART: independent receiver and transmitter, each paced by its own
// counter of BAUD_DIV clocks per bit.
module UART
  import quad_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int unsigned    CW         = $clog2(BAUD_DIV * 2);
  localparam logic [CW-1:0]  START_LOAD = CW'(BAUD_DIV + BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  BIT_LOAD   = CW'(BAUD_DIV - 1);

  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [8:0]    rx_shift;

  logic [9:0]    tx_shift;
  logic          tx_busy;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bits;

  assign rx_data = rx_shift[7:0];
  assign TX      = tx_shift[0];

  // The ninth sample is the stop bit; it shifts in above the data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_ff2   <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_ff2) begin
          rx_busy <= 1'b1;
          rx_baud <= START_LOAD;
          rx_bits <= '0;
        end
      end else if (rx_baud == '0) begin
        rx_shift <= {rx_ff2, rx_shift[8:1]};
        rx_baud  <= BIT_LOAD;
        if (rx_bits == 4'd8) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end else begin
          rx_bits <= rx_bits + 4'd1;
        end
      end else begin
        rx_baud <= rx_baud - 1'b1;
      end
    end
  end

  // Ones shift in behind the frame so TX idles high once the stop bit has gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_shift <= {1'b1, tx_data, 1'b0};
          tx_busy  <= 1'b1;
          tx_baud  <= BIT_LOAD;
          tx_bits  <= '0;
        end
      end else if (tx_baud == '0) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_baud  <= BIT_LOAD;
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_bits <= tx_bits + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_wrapper.sv
// Assembles 3-byte command frames from the UART for cmd_cfg and sends
// single-byte responses on request.
module uart_wrapper
  import quad_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        resp_sent
);

  frame_state_t state;
  logic         rx_rdy;
  logic [7:0]   rx_data;

  // rx_rdy is acknowledged on the cycle after it rises, making it a pulse.
  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (rx_rdy),
    .rx_data    (rx_data),
    .trmt       (send_resp),
    .tx_data    (resp),
    .tx_done    (resp_sent)
  );

  // The DLO capture is written last so it overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CMD;
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (rx_rdy) begin
        case (state)
          CMD: begin
            cmd     <= rx_data;
            cmd_rdy <= 1'b0;
            state   <= DHI;
          end
          DHI: begin
            data[15:8] <= rx_data;
            state      <= DLO;
          end
          DLO: begin
            data[7:0] <= rx_data;
            cmd_rdy   <= 1'b1;
            state     <= CMD;
          end
          default: state <= CMD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed and randomised checks of uart_wrapper against a byte-stream model.
module tb_uart_wrapper;
  import quad_pkg::*;

  localparam int unsigned BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = '0;
  logic        TX;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        resp_sent;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  bit         m_cleared = 1'b0;
  int         rdy_hi_cnt = 0;

  uart_wrapper #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cmd_rdy === 1'b1) rdy_hi_cnt = rdy_hi_cnt + 1;
  end

  // Expected outputs derived from the byte stream received since reset.
  function automatic logic [7:0] exp_cmd();
    int n = rxq.size();
    if (n < 1) return 8'h00;
    return rxq[((n - 1) / 3) * 3];
  endfunction

  function automatic logic [15:0] exp_data();
    int n = rxq.size();
    logic [15:0] d = 16'h0000;
    if (n >= 2) d[15:8] = rxq[((n - 2) / 3) * 3 + 1];
    if (n >= 3) d[7:0]  = rxq[((n - 3) / 3) * 3 + 2];
    return d;
  endfunction

  function automatic logic exp_rdy();
    int n = rxq.size();
    return (n > 0) && (n % 3 == 0) && !m_cleared;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cmd"}, {24'h0, cmd}, {24'h0, exp_cmd()});
    chk({tag, "_data"}, {16'h0, data}, {16'h0, exp_data()});
    chk({tag, "_rdy"}, {31'h0, cmd_rdy}, {31'h0, exp_rdy()});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit chk_pre);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      if (i == 9 && chk_pre) chk("rdy_before_capture", {31'h0, cmd_rdy}, {31'h0, exp_rdy()});
      repeat (BD) @(negedge clk);
    end
    rxq.push_back(b);
    if (rxq.size() % 3 == 0) m_cleared = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input string tag);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    chk_state(tag);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_cleared = 1'b1;
    chk("clr_next_clock", {31'h0, cmd_rdy}, 32'h0);
  endtask

  task automatic tx_check(input logic [7:0] b, input bit inject, input logic [7:0] inj);
    logic [9:0] f;
    int sent;
    f = {1'b1, b, 1'b0};
    sent = 0;
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp = 8'($urandom);
    for (int k = 0; k < 180; k++) begin
      if (k < 160 && k % BD == 0)      chk("tx_bit_first", {31'h0, TX}, {31'h0, f[k / BD]});
      if (k < 160 && k % BD == BD - 1) chk("tx_bit_last", {31'h0, TX}, {31'h0, f[k / BD]});
      if (k == 160) chk("tx_idle_at_done", {31'h0, TX}, 32'h1);
      if (resp_sent === 1'b1) begin
        sent++;
        chk("resp_sent_cycle", k, 160);
      end
      if (inject && k == 50) begin
        resp = inj;
        send_resp = 1'b1;
      end
      if (k == 51) send_resp = 1'b0;
      @(negedge clk);
    end
    chk("resp_sent_count", sent, 1);
  endtask

  initial begin
    int c0;
    int pulses;
    logic [7:0] r0, r1, r2;

    repeat (3) @(negedge clk);
    chk("reset_cmd", {24'h0, cmd}, 32'h0);
    chk("reset_data", {16'h0, data}, 32'h0);
    chk("reset_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("reset_tx", {31'h0, TX}, 32'h1);
    chk("reset_resp_sent", {31'h0, resp_sent}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h02, 8'h12, 8'h34, "frame_0212_34");
    chk("frame1_data_const", {16'h0, data}, 32'h1234);

    send_byte(8'h05, 1'b1);
    chk("opcode_drops_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("opcode_cmd", {24'h0, cmd}, 32'h05);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h80, 1'b1);
    chk_state("frame_05ff80");
    pulse_clr();

    tx_check(POS_ACK, 1'b0, 8'h00);
    tx_check(POS_ACK, 1'b1, 8'h3C);

    send_frame(8'h77, 8'h88, 8'h99, "frame_pre_reset");

    fork
      begin
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
      end
      begin
        repeat (200) @(negedge clk);
        resp = POS_ACK;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
      end
    join
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'h0, TX}, 32'h1);
    chk("async_rst_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("async_rst_cmd", {24'h0, cmd}, 32'h0);
    rxq.delete();
    m_cleared = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_sent === 1'b1 || TX !== 1'b1) pulses++;
    end
    chk("tx_quiet_after_reset", pulses, 0);
    send_frame(8'h03, 8'h00, 8'h64, "frame_after_reset");
    chk("after_reset_data", {16'h0, data}, 32'h0064);

    clr_cmd_rdy = 1'b1;
    c0 = rdy_hi_cnt;
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h0F, 1'b0);
    repeat (5) @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_cleared = 1'b1;
    chk("set_wins_one_cycle", rdy_hi_cnt - c0, 1);
    chk_state("set_wins_frame");

    for (int r = 0; r < 6; r++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      fork
        send_frame(r0, r1, r2, "rand_frame");
        tx_check(8'($urandom), 1'($urandom), 8'($urandom));
      join
      if ($urandom_range(0, 1) == 1) pulse_clr();
      chk_state("rand_hold");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
